// File: rtl/lcd_dma_pkg.sv
// lcd_dma_pkg: shared states, AXI constants and defaults for the LCD framebuffer DMA
package lcd_dma_pkg;
   typedef enum logic [1:0] {IDLE, START, ADDR, DATA} state_t;
   localparam logic [2:0] ARSIZE_4B = 3'b010;
   localparam logic [1:0] ARBURST_INCR = 2'b01;
   localparam int DEF_FRAME_WORDS = 192000;
   localparam int DEF_BURST_LEN = 16;
endpackage

// File: rtl/lcd_framebuffer_burst_reader.sv
// lcd_framebuffer_burst_reader: AXI3 burst reader filling the LCD line FIFO; optional rlast checker via LCD_DMA_RLAST_CHECK_EN
module lcd_framebuffer_burst_reader
   import lcd_dma_pkg::*;
#(
   parameter int FRAME_WORDS = DEF_FRAME_WORDS,
   parameter int BURST_LEN = DEF_BURST_LEN,
   parameter int FIFO_AW = 9
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic              FRAME_START,
   input  logic [29:0]       BUFFER_START_ADDRESS,
   input  logic [FIFO_AW:0]  FIFO_FREE,
   output logic              FIFO_FLUSH,
   output logic              FIFO_WR_EN,
   output logic [31:0]       FIFO_WR_DATA,
   output logic [31:0]       m00_axi_araddr,
   output logic [3:0]        m00_axi_arlen,
   output logic [2:0]        m00_axi_arsize,
   output logic [1:0]        m00_axi_arburst,
   output logic              m00_axi_arvalid,
   input  logic              m00_axi_arready,
   input  logic [31:0]       m00_axi_rdata,
   input  logic              m00_axi_rvalid,
   input  logic              m00_axi_rlast,
   output logic              m00_axi_rready,
   output logic              BUSY,
   output logic              FRAME_DONE,
   output logic              DMA_ERROR
);
   localparam int WCW = $clog2(FRAME_WORDS + 1);
   localparam logic [4:0] LAST_BEAT = 5'(BURST_LEN - 1);
   localparam logic [FIFO_AW:0] NEED_FREE = (FIFO_AW + 1)'(BURST_LEN + 1);
   state_t state_q, state_d;
   logic [29:0] base_q, base_d;
   logic [WCW-1:0] word_cnt_q, word_cnt_d;
   logic [4:0] beat_cnt_q, beat_cnt_d;
   logic arvalid_q, arvalid_d, restart_q, restart_d, done_q, done_d;
   logic beat, last_beat, frame_end;
   assign beat = (state_q == DATA) & m00_axi_rvalid;
   assign last_beat = beat & (beat_cnt_q == LAST_BEAT);
   assign frame_end = (word_cnt_q + WCW'(BURST_LEN)) == WCW'(FRAME_WORDS);
   // State and datapath registers
   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q    <= IDLE;
         base_q     <= '0;
         word_cnt_q <= '0;
         beat_cnt_q <= '0;
         arvalid_q  <= 1'b0;
         restart_q  <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         base_q     <= base_d;
         word_cnt_q <= word_cnt_d;
         beat_cnt_q <= beat_cnt_d;
         arvalid_q  <= arvalid_d;
         restart_q  <= restart_d;
         done_q     <= done_d;
      end
   end
   // Next state: one burst in flight, restart drains the current burst before re-entering START
   always_comb begin
      state_d    = state_q;
      base_d     = base_q;
      word_cnt_d = word_cnt_q;
      beat_cnt_d = beat_cnt_q;
      arvalid_d  = arvalid_q;
      restart_d  = restart_q | ((state_q != IDLE) & FRAME_START);
      done_d     = 1'b0;
      case (state_q)
         IDLE: state_d = FRAME_START ? START : IDLE;
         START: begin
            base_d     = {BUFFER_START_ADDRESS[29:4], 4'b0};
            word_cnt_d = '0;
            beat_cnt_d = '0;
            restart_d  = 1'b0;
            state_d    = ADDR;
         end
         ADDR: begin
            if (arvalid_q) begin
               arvalid_d = ~m00_axi_arready;
               state_d   = m00_axi_arready ? DATA : ADDR;
            end else if (restart_q | FRAME_START) begin
               state_d = START;
            end else begin
               arvalid_d = FIFO_FREE >= NEED_FREE;
            end
         end
         default: begin
            if (beat) beat_cnt_d = beat_cnt_q + 5'd1;
            if (last_beat) begin
               beat_cnt_d = '0;
               word_cnt_d = word_cnt_q + WCW'(BURST_LEN);
               done_d     = frame_end & ~restart_q;
               state_d    = (restart_q | FRAME_START) ? START : (frame_end ? IDLE : ADDR);
            end
         end
      endcase
   end
   // Outputs decoded from state and registered handshake flags
   always_comb begin
      FIFO_FLUSH      = state_q == START;
      BUSY            = state_q != IDLE;
      m00_axi_rready  = state_q == DATA;
      m00_axi_arvalid = arvalid_q;
      m00_axi_araddr  = arvalid_q ? {base_q + 30'(word_cnt_q), 2'b00} : 32'd0;
      m00_axi_arlen   = 4'(BURST_LEN - 1);
      m00_axi_arsize  = ARSIZE_4B;
      m00_axi_arburst = ARBURST_INCR;
      FIFO_WR_EN      = beat & ~restart_q;
      FIFO_WR_DATA    = (beat & ~restart_q) ? m00_axi_rdata : 32'd0;
      FRAME_DONE      = done_q;
   end
`ifdef LCD_DMA_RLAST_CHECK_EN
   logic err_q, err_d;
   logic unused_addr;
   assign unused_addr = ^BUFFER_START_ADDRESS[3:0];
   // Sticky error when rlast disagrees with the internal beat count; cleared on START
   always_comb err_d = (state_q == START) ? 1'b0 : err_q | (beat & (m00_axi_rlast != (beat_cnt_q == LAST_BEAT)));
   // Error flag register
   always_ff @(posedge CLK) err_q <= RESET ? 1'b0 : err_d;
   assign DMA_ERROR = err_q;
`else
   logic unused_in;
   assign unused_in = ^{BUFFER_START_ADDRESS[3:0], m00_axi_rlast};
   assign DMA_ERROR = 1'b0;
`endif
endmodule
